writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The parameter SHALL be: XLEN, default 32, register data width.
REQ-002 The parameter SHALL be: FIFO_DEPTH, default 2, number of entries in the LSU result buffer.
REQ-003 The port SHALL be: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The port SHALL be: rst_b  input  1  reset, synchronous, active-low.
REQ-005 The port SHALL be: alu_valid / alu_rd / alu_data  input  1/5/XLEN  single-cycle result; it is always accepted.
REQ-006 The port SHALL be: lsu_valid / lsu_rd / lsu_data  input  1/5/XLEN  long-latency (load/muldiv) result.
REQ-007 The port SHALL be: lsu_ready  output  1  the LSU result is accepted on an edge where lsu_valid && lsu_ready.
REQ-008 The port SHALL be: mark_valid / mark_rd  input  1/5  decode has issued a long-latency op targeting mark_rd.
REQ-009 The port SHALL be: chk_rs1 / chk_rs2  input  5/5  source registers of the instruction in decode.
REQ-010 The port SHALL be: hazard  output  1  combinational: busy[chk_rs1] | busy[chk_rs2].
REQ-011 The port SHALL be: rd_we / rd_num / rd_data  output  1/5/XLEN  registered regfile write port.
REQ-012 The port SHALL be: sb_err  output  1  sticky flag: mark_valid was asserted on a register that was already busy.
REQ-013 The port SHALL be: halted / wb_idle  input / output  1/1  wb_idle = FIFO empty, rd_we==0, and busy==0.

Function
REQ-014 The block SHALL select at most one write source per cycle, in priority order: ALU, then the FIFO head, then the direct LSU input (the direct path is used only when the FIFO is empty).
REQ-015 A selected source SHALL appear on rd_we/rd_num/rd_data on the next cycle: exactly 1 cycle latency from the input edge to the output.
REQ-016 An accepted LSU result that is not selected in the same cycle SHALL be pushed to the FIFO, which is ordered first-in, first-out.
REQ-017 lsu_ready SHALL equal (FIFO count < FIFO_DEPTH); it SHALL depend on registered state only.
REQ-018 FIFO full: lsu_ready=0, and lsu_valid is ignored. Push and pop in the same cycle SHALL leave the count unchanged.
REQ-019 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, and the count SHALL be kept in a separate register sized 0..FIFO_DEPTH.
REQ-020 A selected source with rd==0 SHALL be consumed but SHALL produce rd_we=0; rd_num and rd_data are don't-care in that case.
REQ-021 The scoreboard SHALL be busy[31:0], with busy[0] hardwired to 0.
REQ-022 mark_valid SHALL set busy[mark_rd] at the clock edge.
REQ-023 busy[r] SHALL clear at the edge that ends a cycle in which rd_we=1, rd_num=r, and the output came from the LSU path (FIFO or direct). ALU writes SHALL NOT clear busy bits.
REQ-024 If a set and a clear target the same register on the same edge, the set SHALL win.
REQ-025 sb_err SHALL set when mark_valid && busy[mark_rd] && mark_rd!=0, and SHALL remain set until reset.
REQ-026 When halted=1, the block SHALL continue draining the FIFO. wb_idle SHALL assert as soon as the drain is complete, and SHALL remain asserted while no new input arrives.

Reset
REQ-027 While rst_b=0 at a rising edge, the block SHALL load: rd_we=0, rd_num=0, rd_data=0, busy=0, FIFO count=0, pointers=0, sb_err=0.
REQ-028 During reset, lsu_ready SHALL be 1 and hazard SHALL be 0; wb_idle SHALL be 1 after the reset edge.
REQ-029 Reset asserted mid-operation SHALL discard all buffered LSU results without issuing writes.
REQ-030 Inputs presented in the reset cycle SHALL have no effect.

Verification
REQ-031 ALU only: alu_valid=1, rd=5, data=0x1234 at edge N -> rd_we=1, rd_num=5, rd_data=0x00001234 during cycle N+1; busy unchanged.
REQ-032 Conflict: ALU (rd=3, 0xA) and LSU (rd=7, 0xB) on the same edge -> cycle N+1 writes x3; cycle N+2 writes x7 from the FIFO.
REQ-033 Back-pressure:
- ALU busy every cycle, with 3 LSU results offered -> the first 2 are accepted; lsu_ready=0 afterwards; the third is held until a pop.
- Once ALU activity stops, the FIFO results are written in order.
REQ-034 Scoreboard: mark rd=9, then chk_rs1=9 -> hazard=1. After the LSU writeback of x9 commits, hazard=0. A second mark of x9 while it is busy -> sb_err=1.
REQ-035 Edge cases:
- Writes to x0 from either source -> rd_we=0.
- rst_b=0 with the FIFO holding 2 entries -> no writes follow, count=0, lsu_ready=1.
- halted=1 -> wb_idle=1 once the FIFO is empty.

Source files
------------

// File: rtl/writeback_unit_if.sv
// Writeback unit bundle: ALU/LSU result inputs, scoreboard mark/check, regfile write port and status.
interface writeback_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            mark_valid;
  logic [4:0]      mark_rd;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic            hazard;
  logic            rd_we;
  logic [4:0]      rd_num;
  logic [XLEN-1:0] rd_data;
  logic            sb_err;
  logic            halted;
  logic            wb_idle;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           mark_valid, mark_rd, chk_rs1, chk_rs2, halted,
    input  lsu_ready, hazard, rd_we, rd_num, rd_data, sb_err, wb_idle
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           mark_valid, mark_rd, chk_rs1, chk_rs2, halted,
    output lsu_ready, hazard, rd_we, rd_num, rd_data, sb_err, wb_idle
  );
endinterface

// File: rtl/writeback_unit.sv
// Regfile writeback arbiter: ALU > buffered LSU > direct LSU, with a busy-register scoreboard.
module writeback_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_b,
  writeback_unit_if.slave wb
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned NREG  = 32;

  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [NREG-1:0]  busy, busy_nxt;

  logic            rd_we_q, rd_from_lsu, sb_err_q;
  logic [4:0]      rd_num_q;
  logic [XLEN-1:0] rd_data_q;

  logic            fifo_empty, lsu_acc, push, pop;
  logic            sel_valid, sel_lsu;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic            unused_halted;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (count == '0);
  assign lsu_acc    = wb.lsu_valid && wb.lsu_ready;

  // Write-source selection; the direct LSU path only bypasses an empty buffer.
  always_comb begin
    sel_valid = 1'b0;
    sel_lsu   = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    pop       = 1'b0;
    if (wb.alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = wb.alu_rd;
      sel_data  = wb.alu_data;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_lsu   = 1'b1;
      sel_rd    = fifo_rd[rd_ptr];
      sel_data  = fifo_data[rd_ptr];
      pop       = 1'b1;
    end else if (lsu_acc) begin
      sel_valid = 1'b1;
      sel_lsu   = 1'b1;
      sel_rd    = wb.lsu_rd;
      sel_data  = wb.lsu_data;
    end
    push = lsu_acc && (wb.alu_valid || !fifo_empty);
  end

  // Clear follows the committed LSU write; a same-edge mark overrides it.
  always_comb begin
    busy_nxt = busy;
    if (rd_we_q && rd_from_lsu) busy_nxt[rd_num_q] = 1'b0;
    if (wb.mark_valid)          busy_nxt[wb.mark_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rd_we_q     <= 1'b0;
      rd_num_q    <= '0;
      rd_data_q   <= '0;
      rd_from_lsu <= 1'b0;
      busy        <= '0;
      sb_err_q    <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      rd_we_q     <= sel_valid && (sel_rd != 5'd0);
      rd_num_q    <= sel_rd;
      rd_data_q   <= sel_data;
      rd_from_lsu <= sel_lsu;
      busy        <= busy_nxt;
      if (wb.mark_valid && (wb.mark_rd != 5'd0) && busy[wb.mark_rd]) sb_err_q <= 1'b1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b && push) begin
      fifo_rd[wr_ptr]   <= wb.lsu_rd;
      fifo_data[wr_ptr] <= wb.lsu_data;
    end
  end

  // The buffer drains the same way whether or not the core is halted.
  assign unused_halted = wb.halted;

  assign wb.lsu_ready = (count < CNT_W'(FIFO_DEPTH));
  assign wb.hazard    = busy[wb.chk_rs1] | busy[wb.chk_rs2];
  assign wb.rd_we     = rd_we_q;
  assign wb.rd_num    = rd_num_q;
  assign wb.rd_data   = rd_data_q;
  assign wb.sb_err    = sb_err_q;
  assign wb.wb_idle   = fifo_empty && !rd_we_q && (busy == '0);
endmodule
